fp8_acc_sequencer: RTL and testbench

- Sequences the registered 8-bit float adder (1-4-3 format) as a running accumulator for the MAC.
- Accepts a stream of `len` FP8 terms over a valid/ready handshake and loads the first term directly into the accumulator.
- Issues each further term to the shared adder as (acc + term) and waits out the adder's 2-cycle latency before the next issue.
- Presents the final sum with sticky overflow/underflow flags over a valid/ready output.

---
 rtl/fp8_pkg.sv | 23 ++
 rtl/fp8_acc_sequencer_if.sv | 36 +++
 rtl/fp8_acc_sequencer.sv | 132 +++++++++++++
 tb/tb_fp8_acc_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// Shared FP8 (1-4-3) definitions and the accumulator sequencer state encoding.
package fp8_pkg;

    localparam int FP8_SIGN_W = 1;
    localparam int FP8_EXP_W  = 4;
    localparam int FP8_FRAC_W = 3;
    localparam int FP8_W      = FP8_SIGN_W + FP8_EXP_W + FP8_FRAC_W;
    localparam int FP8_BIAS   = 7;

    typedef logic [FP8_W-1:0] fp8_t;

    localparam fp8_t FP8_ZERO = 8'h00;
    localparam fp8_t FP8_ONE  = 8'h38;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/fp8_acc_sequencer_if.sv
// Control, term stream, shared-adder and result signals of the FP8 accumulator sequencer.
interface fp8_acc_sequencer_if
    import fp8_pkg::*;
#(
    parameter int LEN_W = 8
) ();

    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    fp8_t             in_data;
    logic             in_ready;
    fp8_t             add_opa;
    fp8_t             add_opb;
    fp8_t             add_result;
    logic             add_ovf;
    logic             add_unf;
    logic             out_valid;
    fp8_t             out_data;
    logic             out_ovf;
    logic             out_unf;
    logic             out_ready;
    logic             busy;

    // The system side: producer, consumer and the shared adder.
    modport master (
        output start, len, in_valid, in_data, add_result, add_ovf, add_unf, out_ready,
        input  in_ready, add_opa, add_opb, out_valid, out_data, out_ovf, out_unf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, add_result, add_ovf, add_unf, out_ready,
        output in_ready, add_opa, add_opb, out_valid, out_data, out_ovf, out_unf, busy
    );

endinterface

// File: rtl/fp8_acc_sequencer.sv
// Runs the shared registered FP8 adder as a running accumulator over a stream of len terms.
module fp8_acc_sequencer
    import fp8_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int ADD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    fp8_acc_sequencer_if.slave bus
);

    localparam int                WCNT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(ADD_LAT - 1);
    localparam logic [LEN_W-1:0]  CNT_ONE   = LEN_W'(1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    fp8_t              r_acc;
    logic [LEN_W-1:0]  r_remaining;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_ovf;
    logic              r_unf;
    logic              w_in_hs;

    assign w_in_hs      = bus.in_valid & bus.in_ready;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.out_data = r_acc;
    assign bus.out_ovf  = r_ovf;
    assign bus.out_unf  = r_unf;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.add_opa   = FP8_ZERO;
        bus.add_opb   = FP8_ZERO;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len == '0) ? ST_DONE : ST_FIRST;
                end
            end
            ST_FIRST: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = (r_remaining == CNT_ONE) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.in_ready = 1'b1;
                // Operands are only presented alongside a live term so the adder sees zeros otherwise.
                if (bus.in_valid) begin
                    bus.add_opa = r_acc;
                    bus.add_opb = bus.in_data;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = (r_remaining == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= FP8_ZERO;
            r_remaining <= '0;
            r_wcnt      <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_remaining <= bus.len;
                        r_ovf       <= 1'b0;
                        r_unf       <= 1'b0;
                        if (bus.len == '0) begin
                            r_acc <= FP8_ZERO;
                        end
                    end
                end
                ST_FIRST: begin
                    if (w_in_hs) begin
                        r_acc       <= bus.in_data;
                        r_remaining <= r_remaining - CNT_ONE;
                    end
                end
                ST_ISSUE: begin
                    if (w_in_hs) begin
                        r_remaining <= r_remaining - CNT_ONE;
                        r_wcnt      <= WCNT_INIT;
                    end
                end
                ST_WAIT: begin
                    // The adder result becomes sampleable ADD_LAT edges after the issue edge.
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - WCNT_W'(1);
                    end else begin
                        r_acc <= bus.add_result;
                        r_ovf <= r_ovf | bus.add_ovf;
                        r_unf <= r_unf | bus.add_unf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_acc_sequencer.sv
// Directed bench for fp8_acc_sequencer with a table-driven 2-stage FP8 adder model.
module tb_fp8_acc_sequencer;
    import fp8_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fp8_acc_sequencer_if #(.LEN_W(8)) bus ();

    fp8_acc_sequencer #(.LEN_W(8), .ADD_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Adder results for the operand pairs this bench issues: {ovf, unf, sum}.
    function automatic logic [9:0] add_fn(input fp8_t a, input fp8_t b);
        logic [9:0] r;
        r = 10'h000;
        if (a == 8'h38 && b == 8'h38) r = {2'b00, 8'h40};
        if (a == 8'h40 && b == 8'h38) r = {2'b00, 8'h44};
        if (a == 8'h70 && b == 8'h70) r = {2'b10, 8'h78};
        if (a == 8'h38 && b == 8'hB8) r = {2'b01, 8'h00};
        return r;
    endfunction

    logic [9:0] add_s1;
    logic [9:0] add_s2;
    always_ff @(posedge clk) begin
        add_s1 <= add_fn(bus.add_opa, bus.add_opb);
        add_s2 <= add_s1;
    end
    assign bus.add_result = add_s2[7:0];
    assign bus.add_unf    = add_s2[8];
    assign bus.add_ovf    = add_s2[9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = FP8_ZERO;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_opa", bus.add_opa, 0);
        check("rst_opb", bus.add_opb, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_flags", {bus.out_ovf, bus.out_unf}, 0);
        rst = 1'b0;
        tick();

        // len=1: first term goes straight into the accumulator, adder untouched.
        bus.start    = 1'b1;
        bus.len      = 8'd1;
        bus.in_valid = 1'b1;
        bus.in_data  = FP8_ONE;
        tick();
        bus.start = 1'b0;
        check("l1_busy", bus.busy, 1);
        check("l1_in_ready", bus.in_ready, 1);
        check("l1_out_valid_early", bus.out_valid, 0);
        check("l1_ops", {bus.add_opa, bus.add_opb}, 0);
        tick();
        bus.in_valid = 1'b0;
        check("l1_out_valid", bus.out_valid, 1);
        check("l1_out_data", bus.out_data, 8'h38);
        check("l1_flags", {bus.out_ovf, bus.out_unf}, 0);
        release_result();
        check("l1_idle_valid", bus.out_valid, 0);
        check("l1_idle_busy", bus.busy, 0);

        // len=3 of 1.0 with in_valid held: accepts after edges 0,1,4, result after edge 7.
        bus.start    = 1'b1;
        bus.len      = 8'd3;
        bus.in_valid = 1'b1;
        bus.in_data  = FP8_ONE;
        for (int k = 0; k < 8; k++) begin
            tick();
            bus.start = 1'b0;
            check($sformatf("l3_in_ready_%0d", k), bus.in_ready, (k == 0 || k == 1 || k == 4) ? 1 : 0);
            check($sformatf("l3_out_valid_%0d", k), bus.out_valid, (k == 7) ? 1 : 0);
            if (k == 1) check("l3_ops_first_issue", {bus.add_opa, bus.add_opb}, 16'h3838);
            if (k == 4) check("l3_ops_second_issue", {bus.add_opa, bus.add_opb}, 16'h4038);
        end
        bus.in_valid = 1'b0;
        check("l3_out_data", bus.out_data, 8'h44);
        check("l3_flags", {bus.out_ovf, bus.out_unf}, 0);
        release_result();

        // len=0: straight to DONE with a zeroed accumulator.
        bus.start = 1'b1;
        bus.len   = 8'd0;
        tick();
        bus.start = 1'b0;
        check("l0_out_valid", bus.out_valid, 1);
        check("l0_out_data", bus.out_data, 0);
        check("l0_in_ready", bus.in_ready, 0);
        check("l0_flags", {bus.out_ovf, bus.out_unf}, 0);
        release_result();

        // 128 + 128 overflows; includes an in_valid gap while in ISSUE.
        bus.start    = 1'b1;
        bus.len      = 8'd2;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h70;
        tick();
        bus.start = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("ovf_gap_ops", {bus.add_opa, bus.add_opb}, 0);
        tick();
        check("ovf_gap_in_ready", bus.in_ready, 1);
        check("ovf_gap_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b1;
        #1;
        check("ovf_issue_ops", {bus.add_opa, bus.add_opb}, 16'h7070);
        tick();
        bus.in_valid = 1'b0;
        check("ovf_wait_in_ready", bus.in_ready, 0);
        check("ovf_wait_ops", {bus.add_opa, bus.add_opb}, 0);
        tick();
        check("ovf_wait_out_valid", bus.out_valid, 0);
        tick();
        check("ovf_out_valid", bus.out_valid, 1);
        check("ovf_out_data", bus.out_data, 8'h78);
        check("ovf_flags", {bus.out_ovf, bus.out_unf}, 2'b10);
        release_result();

        // 1.0 + -1.0 gives exact zero with underflow, then a held DONE ignores start.
        bus.start    = 1'b1;
        bus.len      = 8'd2;
        bus.in_valid = 1'b1;
        bus.in_data  = FP8_ONE;
        tick();
        bus.start = 1'b0;
        tick();
        bus.in_data = 8'hB8;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("unf_out_valid", bus.out_valid, 1);
        check("unf_out_data", bus.out_data, 0);
        check("unf_flags", {bus.out_ovf, bus.out_unf}, 2'b01);
        bus.start = 1'b1;
        bus.len   = 8'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold_out_valid_%0d", k), bus.out_valid, 1);
            check($sformatf("hold_out_data_%0d", k), bus.out_data, 0);
            check($sformatf("hold_flags_%0d", k), {bus.out_ovf, bus.out_unf}, 2'b01);
            check($sformatf("hold_busy_%0d", k), bus.busy, 1);
        end
        bus.start = 1'b0;
        release_result();
        check("unf_idle_valid", bus.out_valid, 0);
        check("unf_idle_busy", bus.busy, 0);
        check("unf_idle_retained", {bus.out_ovf, bus.out_unf, bus.out_data}, 10'h100);

        // Reset in WAIT of a len=3 run, then a clean len=1 run.
        bus.start    = 1'b1;
        bus.len      = 8'd3;
        bus.in_valid = 1'b1;
        bus.in_data  = FP8_ONE;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("wait_busy", bus.busy, 1);
        check("wait_in_ready", bus.in_ready, 0);
        check("wait_acc", bus.out_data, 8'h38);
        rst = 1'b1;
        #1;
        check("rstw_out_valid", bus.out_valid, 0);
        check("rstw_busy", bus.busy, 0);
        check("rstw_acc", bus.out_data, 0);
        check("rstw_flags", {bus.out_ovf, bus.out_unf}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", bus.busy, 0);
        bus.start    = 1'b1;
        bus.len      = 8'd1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h40;
        tick();
        bus.start = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("post_rst_out_valid", bus.out_valid, 1);
        check("post_rst_out_data", bus.out_data, 8'h40);
        check("post_rst_flags", {bus.out_ovf, bus.out_unf}, 0);
        release_result();
        check("post_rst_done_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
